led_frame_reader: RTL and testbench

LED_FRAME_READER -- requirements
Module: led_frame_reader

---
 rtl/led_frame_reader_pkg.sv | 22 ++
 rtl/led_frame_reader_latch.sv | 36 +++
 rtl/led_frame_reader.sv | 160 ++++++++++++++++
 tb/tb_led_frame_reader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_reader_pkg.sv
// Shared definitions for the LED frame reader.
//   state_t          : frame reader FSM states
//   RAM_AW / RAM_DW  : pixel RAM address / data widths
//   PIX_W            : pixel width handed to the serializer (GRB, 8 bits each)
//   DEF_LATCH_CYCLES : default idle-low latch time after a frame (50 us @ 50 MHz)
package led_frame_reader_pkg;

  localparam int unsigned RAM_AW           = 9;
  localparam int unsigned RAM_DW           = 32;
  localparam int unsigned PIX_W            = 24;
  localparam int unsigned DEF_LATCH_CYCLES = 2500;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT1,
    WAIT2,
    PRESENT,
    LATCH
  } state_t;

endpackage

// File: rtl/led_frame_reader_latch.sv
// latch_timer: counts the LED latch (reset-low) period after a frame.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   load           : restart the count from zero
//   count          : advance the count this cycle
//   done           : high on the last counted cycle (LATCH_CYCLES-th)
module latch_timer
  import led_frame_reader_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATCH_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign done = count && (cnt == LAST);

  // Clearing on done leaves the counter at zero between frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load || done) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_frame_reader.sv
// led_frame_reader: walks a pixel RAM once per frame and hands each pixel to
// an LED serializer with a valid/ready handshake, then holds the line idle for
// the latch period.
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   start                 : frame request (one-deep pending if busy)
//   rdaddress, q          : RAM read port, 2-cycle read latency; q[23:0] = GRB
//   pix_data, pix_valid,
//   pix_ready             : pixel handshake towards the serializer
//   busy                  : FSM not in IDLE
//   frame_done            : one-cycle pulse after frame plus latch
//   swap_req, bank        : double-buffer control, only with BANK_SWAP_EN
// Optional feature macro: BANK_SWAP_EN (two 256-pixel banks selected by bank).
module led_frame_reader
  import led_frame_reader_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [RAM_AW-1:0] rdaddress,
  input  logic [RAM_DW-1:0] q,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
`ifdef BANK_SWAP_EN
  ,
  input  logic              swap_req,
  output logic              bank
`endif
);

  localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(NUM_LEDS - 1);

  state_t            state, state_nxt;
  logic [RAM_AW-1:0] index, idx_next, addr_next;
  logic              pending, go, transfer, last;
  logic              tmr_load, tmr_count, tmr_done;
  logic              unused_q_hi;

  assign unused_q_hi = ^q[RAM_DW-1:PIX_W];

  assign busy     = (state != IDLE);
  assign go       = (state == IDLE) && (start || pending);
  assign transfer = (state == PRESENT) && pix_ready;
  assign last     = (index == LAST_IDX);

  always_comb begin
    idx_next = index;
    if (go) begin
      idx_next = '0;
    end else if (transfer && !last) begin
      idx_next = index + RAM_AW'(1);
    end
  end

`ifdef BANK_SWAP_EN
  logic swap_flag, bank_nxt;

  // The new bank must already be on rdaddress for the first pixel of the frame.
  assign bank_nxt  = (go && swap_flag) ? ~bank : bank;
  assign addr_next = {bank_nxt, idx_next[7:0]};

  // A swap_req coinciding with a frame start is kept for the following frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank      <= 1'b0;
      swap_flag <= 1'b0;
    end else begin
      bank <= bank_nxt;
      if (go) begin
        swap_flag <= swap_req;
      end else if (swap_req) begin
        swap_flag <= 1'b1;
      end
    end
  end
`else
  assign addr_next = idx_next;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    case (state)
      IDLE:    if (go) state_nxt = ADDR;
      ADDR:    state_nxt = WAIT1;
      WAIT1:   state_nxt = WAIT2;
      WAIT2:   state_nxt = PRESENT;
      PRESENT: begin
        if (pix_ready) begin
          if (last) begin
            state_nxt = LATCH;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = ADDR;
          end
        end
      end
      LATCH: begin
        tmr_count = 1'b1;
        if (tmr_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdaddress is loaded on entry to ADDR, so the RAM's address register
  // captures it at the end of ADDR and q is valid during WAIT2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      index      <= '0;
      rdaddress  <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      index      <= idx_next;
      frame_done <= (state == LATCH) && tmr_done;
      if (go) begin
        pending <= 1'b0;
      end else if (start && busy) begin
        pending <= 1'b1;
      end
      if (go || (transfer && !last)) begin
        rdaddress <= addr_next;
      end
      if (state == WAIT2) begin
        pix_data  <= q[PIX_W-1:0];
        pix_valid <= 1'b1;
      end else if (transfer) begin
        pix_valid <= 1'b0;
      end
    end
  end

  latch_timer #(
    .LATCH_CYCLES(LATCH_CYCLES)
  ) u_latch (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (tmr_load),
    .count  (tmr_count),
    .done   (tmr_done)
  );

endmodule

// File: tb/tb_led_frame_reader.sv
`timescale 1ns/1ps
module tb_led_frame_reader;

  localparam int NLED = 8;
  localparam int LAT  = 20;

  logic        clock = 1'b0;
  logic        reset_n, start, pix_ready;
  logic [8:0]  rdaddress;
  logic [31:0] q1;
  logic [23:0] pix_data;
  logic        pix_valid, busy, frame_done;
`ifdef BANK_SWAP_EN
  logic        swap_req, bank;
  logic        swap_req2, bank2;
`endif

  logic        start2, pix_ready2;
  logic [8:0]  rdaddress2;
  logic [31:0] q2;
  logic [23:0] pix_data2;
  logic        pix_valid2, busy2, frame_done2;

  logic [31:0] mem  [0:511];
  logic [31:0] mem2 [0:511];
  logic [8:0]  ra1, ra2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  led_frame_reader #(.NUM_LEDS(NLED), .LATCH_CYCLES(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .rdaddress(rdaddress),
    .q(q1), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done)
`ifdef BANK_SWAP_EN
    , .swap_req(swap_req), .bank(bank)
`endif
  );

  led_frame_reader #(.NUM_LEDS(1), .LATCH_CYCLES(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .rdaddress(rdaddress2),
    .q(q2), .pix_data(pix_data2), .pix_valid(pix_valid2), .pix_ready(pix_ready2),
    .busy(busy2), .frame_done(frame_done2)
`ifdef BANK_SWAP_EN
    , .swap_req(swap_req2), .bank(bank2)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM models: address register then output register
  always @(posedge clock) begin
    ra1 <= rdaddress;
    q1  <= mem[ra1];
    ra2 <= rdaddress2;
    q2  <= mem2[ra2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: expected pixel stream is RAM[bank*256 + i] for i = 0..NLED-1 per
  // frame; frame_done is due LAT+1 cycles after the last transfer.
  int          xfer_cyc[$];
  logic [23:0] xfer_pix[$];
  int          done_cyc[$];
  int          m_idx = 0, m_due = -1, m_bank = 0, m_swap = 0;
  logic        m_pv = 1'b0, m_pr = 1'b0;
  logic [23:0] m_pd = '0;
  logic [8:0]  ea;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_rdaddress", rdaddress, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
`ifdef BANK_SWAP_EN
      check("rst_bank", bank, 0);
`endif
      m_idx = 0; m_due = -1; m_bank = 0; m_swap = 0; m_pv = 1'b0;
    end else begin
`ifdef BANK_SWAP_EN
      if (swap_req) m_swap = 1;
`endif
      if (m_pv && !m_pr) begin
        check("hold_valid", pix_valid, 1);
        check("hold_data", pix_data, m_pd);
      end
      if (pix_valid) check("busy_while_valid", busy, 1);
      if (pix_valid && pix_ready) begin
        if (m_idx == 0 && m_swap != 0) begin
          m_bank = 1 - m_bank;
          m_swap = 0;
        end
`ifdef BANK_SWAP_EN
        ea = {m_bank[0], m_idx[7:0]};
`else
        ea = m_idx[8:0];
`endif
        check("xfer_data", pix_data, mem[ea][23:0]);
        check("xfer_addr", rdaddress, ea);
        xfer_cyc.push_back(cyc);
        xfer_pix.push_back(pix_data);
        if (m_idx == NLED - 1) begin
          m_idx = 0;
          m_due = cyc + LAT + 1;
        end else begin
          m_idx++;
        end
      end
      check("frame_done_timing", frame_done, (cyc == m_due) ? 1 : 0);
      if (frame_done) begin
        check("idle_at_done", busy, 0);
        done_cyc.push_back(cyc);
      end
      m_pv = pix_valid; m_pr = pix_ready; m_pd = pix_data;
    end
  end

  task automatic pulse_start(output int s);
    @(posedge clock); #1;
    start = 1'b1; s = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input string tag);
    int k = 0;
    while (xfer_pix.size() < n && k < 3000) begin
      @(posedge clock); #1; k++;
    end
    check(tag, xfer_pix.size(), n);
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (done_cyc.size() < n && k < 3000) begin
      @(posedge clock); #1; k++;
    end
    check(tag, done_cyc.size(), n);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!pix_valid && k < 50) begin
      @(posedge clock); #1; k++;
    end
    check(tag, pix_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, tmp, b, d, s2, x2, dd, n2;
    logic [23:0] p2;
    for (int i = 0; i < 512; i++) begin
      mem[i]  = 32'hAA000000 | i;
      mem2[i] = 32'h0;
    end
    mem2[0] = 32'h11ABCDEF;
    reset_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
    start2 = 1'b0; pix_ready2 = 1'b1;
`ifdef BANK_SWAP_EN
    swap_req = 1'b0; swap_req2 = 1'b0;
`endif
    #1;
    check("t0_rdaddress", rdaddress, 0);
    check("t0_busy", busy, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // One frame, ready held high
    b = xfer_pix.size(); d = done_cyc.size();
    pulse_start(s);
    wait_done(d + 1, "s1_done_seen");
    check("s1_done_latency", done_cyc[d] - s, 4 * NLED + LAT + 1);
    check("s1_xfer_count", xfer_pix.size() - b, NLED);
    check("s1_first_latency", xfer_cyc[b] - s, 4);
    for (int i = 0; i < NLED; i++) begin
      check("s1_pix", xfer_pix[b + i], i);
      if (i > 0) check("s1_gap", xfer_cyc[b + i] - xfer_cyc[b + i - 1], 4);
    end

    // Back-pressure on pixel 3 for 10 cycles
    b = xfer_pix.size(); d = done_cyc.size();
    pulse_start(s);
    wait_xfers(b + 3, "s2_three_xfers");
    pix_ready = 1'b0;
    wait_valid("s2_valid_seen");
    for (int i = 0; i < 10; i++) begin
      check("s2_stall_data", pix_data, 24'h000003);
      check("s2_stall_valid", pix_valid, 1);
      check("s2_stall_addr", rdaddress, 3);
      @(posedge clock); #1;
    end
    pix_ready = 1'b1;
    wait_done(d + 1, "s2_done_seen");
    check("s2_xfer_count", xfer_pix.size() - b, NLED);
    check("s2_pix3", xfer_pix[b + 3], 24'h000003);

    // Starts during pixels 2 and 5: exactly one extra back-to-back frame
    b = xfer_pix.size(); d = done_cyc.size();
    pulse_start(s);
    wait_xfers(b + 2, "s3_at_pix2");
    pulse_start(tmp);
    wait_xfers(b + 5, "s3_at_pix5");
    pulse_start(tmp);
    wait_done(d + 1, "s3_first_done");
    check("s3_restart_busy", busy, 1);
    check("s3_restart_addr", rdaddress, 0);
    wait_done(d + 2, "s3_second_done");
    repeat (80) @(posedge clock);
    #1;
    check("s3_frame_count", done_cyc.size() - d, 2);
    check("s3_xfer_count", xfer_pix.size() - b, 2 * NLED);
    check("s3_idle_after", busy, 0);

    // Asynchronous reset while pixel 4 is presented, with a start pending
    b = xfer_pix.size();
    pulse_start(s);
    wait_xfers(b + 1, "s4_first_xfer");
    pulse_start(tmp);
    wait_xfers(b + 4, "s4_four_xfers");
    pix_ready = 1'b0;
    wait_valid("s4_valid_seen");
    check("s4_pre_data", pix_data, 24'h000004);
    reset_n = 1'b0;
    #1;
    check("s4_async_rdaddress", rdaddress, 0);
    check("s4_async_pix_data", pix_data, 0);
    check("s4_async_pix_valid", pix_valid, 0);
    check("s4_async_busy", busy, 0);
    check("s4_async_frame_done", frame_done, 0);
    pix_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      check("s4_no_pending", busy, 0);
    end
    b = xfer_pix.size(); d = done_cyc.size();
    pulse_start(s);
    wait_done(d + 1, "s4_done_seen");
    check("s4_first_latency", xfer_cyc[b] - s, 4);
    check("s4_xfer_count", xfer_pix.size() - b, NLED);
    check("s4_pix1", xfer_pix[b + 1], 24'h000001);

    // Single-pixel instance with one-cycle latch
    @(posedge clock); #1;
    start2 = 1'b1; s2 = cyc;
    @(posedge clock); #1;
    start2 = 1'b0;
    x2 = -1; dd = -1; n2 = 0; p2 = '0;
    for (int k = 0; k < 20; k++) begin
      if (pix_valid2 && pix_ready2) begin
        n2++; x2 = cyc; p2 = pix_data2;
      end
      if (frame_done2 && dd < 0) dd = cyc;
      @(posedge clock); #1;
    end
    check("s6_xfer_count", n2, 1);
    check("s6_pix", p2, 24'hABCDEF);
    check("s6_first_latency", x2 - s2, 4);
    check("s6_done_after_xfer", dd - x2, 2);
    check("s6_idle", busy2, 0);

`ifdef BANK_SWAP_EN
    // Swap request mid-frame takes effect on the next frame
    b = xfer_pix.size(); d = done_cyc.size();
    pulse_start(s);
    wait_xfers(b + 3, "bk_mid_frame");
    @(posedge clock); #1 swap_req = 1'b1;
    @(posedge clock); #1 swap_req = 1'b0;
    wait_done(d + 1, "bk_first_done");
    check("bk_bank_before", bank, 0);
    check("bk_old_pix7", xfer_pix[b + 7], 24'h000007);
    pulse_start(s);
    check("bk_bank_after", bank, 1);
    wait_done(d + 2, "bk_second_done");
    check("bk_new_pix0", xfer_pix[b + 8], 24'h000100);
    check("bk_new_pix7", xfer_pix[b + 15], 24'h000107);
    check("bk_addr_last", rdaddress, 9'h107);
`endif

    repeat (5) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
